// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Byte-addressed data memory that serves the load/store requests of the multicycle control unit.
//   A one-cycle memRead/memWrite strobe captured in IDLE is answered by a one-cycle memReady pulse
//   after WAIT_CYCLES wait states. The block supports 16-bit little-endian word accesses and 8-bit
//   byte accesses. Byte loads are zero- or sign-extended.
//
//   Optional feature macro: DMEM_ALIGN_CHECK_EN
//     When it is defined, a word access at an odd address completes with normal timing. memErr is
//     raised with memReady, the load returns 0, and the store is suppressed.
//     When it is undefined, memErr is tied to 0 and misaligned words are accessed normally.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; aborts an in-flight request
//   memRead   load strobe, sampled only in IDLE
//   memWrite  store strobe, sampled only in IDLE; wins when both strobes are high
//   wrByte    1 = byte access, 0 = word access
//   signW2B   byte loads: 1 = sign-extend, 0 = zero-extend
//   addr      byte address; only the low log2(DEPTH_BYTES) bits are used
//   dataIn    store data; byte stores use dataIn[7:0]
//   dataOut   load data, valid while memReady=1, 0 otherwise
//   memReady  one-cycle completion pulse
//   memBusy   high while a request is in flight
//   memErr    one-cycle error pulse coincident with memReady
module data_mem_responder #(
    parameter int DATA_W      = 16,   // must be 16
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 512,  // power of two, at most 2**ADDR_W
    parameter int WAIT_CYCLES = 1     // 0..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              wrByte,
    input  logic              signW2B,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              memReady,
    output logic              memBusy,
    output logic              memErr
);

    localparam int         IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [IDX_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              byte_q, byte_d;
    logic              sign_q, sign_d;
    logic              wr_q, wr_d;

    logic              ready_d;
    logic              err_d;
    logic [DATA_W-1:0] dout_d;
    logic              we;

    logic [7:0]        mem [DEPTH_BYTES];
    logic [IDX_W-1:0]  a_hi;
    logic [7:0]        rd_lo, rd_hi;
    logic              misalign;

    // Address bits above the storage size alias silently onto the array.
    generate
        if (IDX_W < ADDR_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    // The high byte of a word at the top address wraps to byte 0.
    assign a_hi  = a_q + IDX_W'(1);
    assign rd_lo = mem[a_q];
    assign rd_hi = mem[a_hi];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = ~byte_q & a_q[0];
`else
    assign misalign = 1'b0;
`endif

    assign memBusy = (state != IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        a_d     = a_q;
        d_d     = d_q;
        byte_d  = byte_q;
        sign_d  = sign_q;
        wr_d    = wr_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        dout_d  = '0;
        we      = 1'b0;
        case (state)
            IDLE: begin
                if (memRead || memWrite) begin
                    a_d    = addr[IDX_W-1:0];
                    d_d    = dataIn;
                    byte_d = wrByte;
                    sign_d = signW2B;
                    wr_d   = memWrite;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            DONE: begin
                // Response and store both take effect on the edge leaving DONE,
                // so memReady is seen in the first cycle back in IDLE.
                ready_d = 1'b1;
                err_d   = misalign;
                if (wr_q) begin
                    we = ~misalign;
                end else if (!misalign) begin
                    if (byte_q) begin
                        dout_d = {{8{sign_q & rd_lo[7]}}, rd_lo};
                    end else begin
                        dout_d = {rd_hi, rd_lo};
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            d_q      <= '0;
            byte_q   <= 1'b0;
            sign_q   <= 1'b0;
            wr_q     <= 1'b0;
            memReady <= 1'b0;
            memErr   <= 1'b0;
            dataOut  <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            a_q      <= a_d;
            d_q      <= d_d;
            byte_q   <= byte_d;
            sign_q   <= sign_d;
            wr_q     <= wr_d;
            memReady <= ready_d;
            memErr   <= err_d;
            dataOut  <= dout_d;
        end
    end

    // Storage is not reset; a word store writes both bytes in the same clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[a_q] <= d_q[7:0];
            if (!byte_q) begin
                mem[a_hi] <= d_q[15:8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int DEPTH = 512;
    localparam int WAITS = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead, memWrite, wrByte, signW2B;
    logic [15:0] addr, dataIn;
    logic [15:0] dataOut;
    logic        memReady, memBusy, memErr;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [DEPTH];

    data_mem_responder #(
        .DATA_W(16),
        .ADDR_W(16),
        .DEPTH_BYTES(DEPTH),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .memRead(memRead),
        .memWrite(memWrite),
        .wrByte(wrByte),
        .signW2B(signW2B),
        .addr(addr),
        .dataIn(dataIn),
        .dataOut(dataOut),
        .memReady(memReady),
        .memBusy(memBusy),
        .memErr(memErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [15:0] a, input logic byt);
`ifdef DMEM_ALIGN_CHECK_EN
        return (!byt && (a % 2 == 1));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] model_load(input logic [15:0] a, input logic byt, input logic sgn);
        int lo_i, hi_i;
        int lo, hi;
        lo_i = a % DEPTH;
        hi_i = (lo_i + 1) % DEPTH;
        lo   = ref_mem[lo_i];
        hi   = ref_mem[hi_i];
        if (model_err(a, byt)) return 16'h0000;
        if (byt) return (sgn && lo >= 128) ? 16'(32'hFF00 + lo) : 16'(lo);
        return 16'(hi * 256 + lo);
    endfunction

    function automatic void model_store(input logic [15:0] a, input logic byt, input logic [15:0] d);
        int i;
        i = a % DEPTH;
        if (model_err(a, byt)) return;
        ref_mem[i] = d[7:0];
        if (!byt) ref_mem[(i + 1) % DEPTH] = d[15:8];
    endfunction

    // One request: strobes held for 'hold' sampling edges, response checked against the model.
    task automatic req(input logic rd, input logic wr, input logic byt, input logic sgn,
                       input logic [15:0] a, input logic [15:0] d, input int hold,
                       output logic [15:0] got);
        logic [15:0] exp_d;
        bit          exp_e;
        bit          done;
        int          e;
        exp_d = model_load(a, byt, sgn);
        exp_e = model_err(a, byt);
        got   = 16'h0;
        @(negedge clk);
        memRead = rd; memWrite = wr; wrByte = byt; signW2B = sgn; addr = a; dataIn = d;
        done = 0;
        e    = 0;
        while (!done && e < 30) begin
            @(posedge clk); #1;
            if (e + 1 >= hold) begin
                memRead  = 1'b0;
                memWrite = 1'b0;
            end
            if (e >= 1 && memReady) begin
                done = 1;
            end else begin
                if (e >= 1) begin
                    chk("busy_in_flight", 32'(memBusy), 32'd1);
                    chk("dout_zero_in_flight", 32'(dataOut), 32'd0);
                end
                e++;
            end
        end
        if (!done) begin
            chk("ready_timeout", 32'(memReady), 32'd1);
            return;
        end
        got = dataOut;
        chk("latency", 32'(e), 32'(WAITS + 1));
        chk("err_flag", 32'(memErr), 32'(exp_e));
        chk("busy_at_ready", 32'(memBusy), 32'd0);
        if (!wr) chk("load_data", 32'(dataOut), 32'(exp_d));
        if (wr) model_store(a, byt, d);
        @(posedge clk); #1;
        chk("single_pulse", 32'(memReady), 32'd0);
        chk("dout_after_pulse", 32'(dataOut), 32'd0);
        chk("err_after_pulse", 32'(memErr), 32'd0);
    endtask

    initial begin
        logic [15:0] g;
        rst_n = 1'b0;
        memRead = 1'b0; memWrite = 1'b0; wrByte = 1'b0; signW2B = 1'b0;
        addr = '0; dataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(memReady), 32'd0);
        chk("rst_busy", 32'(memBusy), 32'd0);
        chk("rst_err", 32'(memErr), 32'd0);
        chk("rst_dout", 32'(dataOut), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Fill the whole array with known random words so the model tracks every byte.
        for (int i = 0; i < DEPTH; i += 2) begin
            req(1'b0, 1'b1, 1'b0, 1'b0, 16'(i), 16'($urandom), 1, g);
        end

        // Word store then word load.
        req(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 1, g);
        req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1, g);
        chk("t1_word", 32'(g), 32'h0000BEEF);
        req(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1, g);
        chk("t1_lo_byte", 32'(g), 32'h000000EF);
        req(1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1, g);
        chk("t1_hi_byte", 32'(g), 32'h000000BE);

        // Byte store, zero/sign-extended byte loads, neighbour untouched.
        req(1'b0, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h5580, 1, g);
        req(1'b1, 1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1, g);
        chk("t2_zext", 32'(g), 32'h00000080);
        req(1'b1, 1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 1, g);
        chk("t2_sext", 32'(g), 32'h0000FF80);
        req(1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1, g);

        // Strobe held while busy is ignored; both strobes act as a store.
        req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, g);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_extra_ready", 32'(memReady), 32'd0);
        end
        req(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'hA5A5, 1, g);
        req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1, g);
        chk("t3_both_store", 32'(g), 32'h0000A5A5);

        // Top-of-array wrap and address aliasing.
        req(1'b0, 1'b1, 1'b0, 1'b0, 16'h01FF, 16'h1234, 1, g);
        req(1'b1, 1'b0, 1'b1, 1'b0, 16'h01FF, 16'h0000, 1, g);
`ifndef DMEM_ALIGN_CHECK_EN
        chk("t4_top_byte", 32'(g), 32'h00000034);
`endif
        req(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1, g);
`ifndef DMEM_ALIGN_CHECK_EN
        chk("t4_wrap_byte", 32'(g), 32'h00000012);
`endif
        req(1'b0, 1'b1, 1'b0, 1'b0, 16'h0210, 16'hCAFE, 1, g);
        req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1, g);
        chk("t4_alias", 32'(g), 32'h0000CAFE);

        // Reset during WAIT of a store drops it.
        @(negedge clk);
        memWrite = 1'b1; wrByte = 1'b0; addr = 16'h0030; dataIn = 16'h7777;
        @(posedge clk); #1;
        memWrite = 1'b0;
        chk("t5_busy_before", 32'(memBusy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_ready", 32'(memReady), 32'd0);
        chk("t5_busy", 32'(memBusy), 32'd0);
        chk("t5_err", 32'(memErr), 32'd0);
        chk("t5_dout", 32'(dataOut), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 1, g);

`ifdef DMEM_ALIGN_CHECK_EN
        req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0013, 16'h0000, 1, g);
        chk("t6_load_zero", 32'(g), 32'd0);
        req(1'b0, 1'b1, 1'b0, 1'b0, 16'h0013, 16'hDEAD, 1, g);
        req(1'b1, 1'b0, 1'b1, 1'b0, 16'h0013, 16'h0000, 1, g);
        req(1'b1, 1'b0, 1'b1, 1'b0, 16'h0014, 16'h0000, 1, g);
`endif

        // Randomized mix of loads, stores and simultaneous strobes over the full address range.
        for (int i = 0; i < 200; i++) begin
            int unsigned op;
            op = $urandom_range(0, 3);
            req((op == 0 || op == 2 || op == 3) ? 1'b1 : 1'b0,
                (op == 1 || op == 2) ? 1'b1 : 1'b0,
                1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1, g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
